// File: rtl/kernel_bc_start_rx_pkg.sv
// rtl/kernel_bc_start_rx_pkg.sv - shared types and constants for the write_back start-token controller
package kernel_bc_start_rx_pkg;

    localparam int CNT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/kernel_bc_start_rx_counter.sv
// rtl/kernel_bc_start_rx_counter.sv - wrapping statistics counter with asynchronous active-low clear
//
// Ports:
//   clk      clock
//   clear_n  asynchronous active-low clear to zero
//   inc      count enable, one increment per cycle
//   count    current value, wraps modulo 2^CNT_WIDTH
module kernel_bc_start_rx_counter
    import kernel_bc_start_rx_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/kernel_bc_start_rx_write_back.sv
// rtl/kernel_bc_start_rx_write_back.sv - start-token consumer driving the write_back ap_ctrl_chain handshake
//
// Pops one token from the start-propagation FIFO per run, holds it on token,
// drives ap_start until ap_ready, waits for ap_done and acknowledges it with a
// one-cycle ap_continue. A new token may be popped in the acknowledge cycle,
// giving a two-cycle minimum per token.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   fifo_empty_n, fifo_dout  FIFO head status and data
//   fifo_read                FIFO pop strobe (combinational)
//   drain                    blocks new pops; a run in progress still completes
//   ap_start/ap_ready/ap_done/ap_idle/ap_continue  write_back control handshake
//   token                    token of the current run
//   busy, stage_idle         occupancy and upstream idle report
//   run_count, pop_count     statistics
//
// Build option: KERNEL_BC_START_RX_STATS_EN implements the statistics
// counters; without it both counter ports are tied to zero.
module kernel_bc_start_rx_write_back
    import kernel_bc_start_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    input  logic                  drain,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    output logic                  ap_continue,
    output logic [DATA_WIDTH-1:0] token,
    output logic                  busy,
    output logic                  stage_idle,
    output logic [CNT_WIDTH-1:0]  run_count,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    state_t state;
    state_t state_nxt;

    // Gated by reset_n so no token is popped (and lost) while reset is held.
    assign fifo_read = reset_n & ((state == IDLE) | (state == ACK)) & fifo_empty_n & ~drain;

    assign busy       = (state != IDLE);
    assign stage_idle = ap_idle & ~busy & ~fifo_empty_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            token <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_read) begin
                token <= fifo_dout;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_read) state_nxt = START;
            end
            START: begin
                ap_start = 1'b1;
                if (ap_ready && ap_done) state_nxt = ACK;
                else if (ap_ready)       state_nxt = RUN;
            end
            RUN: begin
                if (ap_done) state_nxt = ACK;
            end
            ACK: begin
                ap_continue = 1'b1;
                state_nxt   = fifo_read ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef KERNEL_BC_START_RX_STATS_EN
    kernel_bc_start_rx_counter #(.CNT_WIDTH(CNT_WIDTH)) u_run_cnt (
        .clk     (clk),
        .clear_n (reset_n),
        .inc     (state == ACK),
        .count   (run_count)
    );

    kernel_bc_start_rx_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pop_cnt (
        .clk     (clk),
        .clear_n (reset_n),
        .inc     (fifo_read),
        .count   (pop_count)
    );
`else
    assign run_count = '0;
    assign pop_count = '0;
`endif

endmodule
